// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: segment bit
// positions, the active-high hex glyph table and the scan state encoding.
package display_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // {g,f,e,d,c,b,a}, active-high; b and d are lower-case glyphs
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef enum logic {
      LIT   = 1'b0,
      GUARD = 1'b1
   } scan_state_t;

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to seven-segment glyph lookup (active-high).
module hex_to_seven_seg
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/display_scanner.sv
// Multiplexed seven-segment scan controller with per-digit dwell, all-off guard
// interval, blanking, decimal points and leading-zero suppression.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   LIT   | digit idx driven for PRESCALE enabled cycles
//   GUARD | all anodes off for GUARD_CYCLES enabled cycles, then advance
module display_scanner
   import display_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 100000,
   parameter int GUARD_CYCLES = 2,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [4*NUM_DIGITS-1:0]       digit_values,
   input  logic [NUM_DIGITS-1:0]         digit_blank,
   input  logic [NUM_DIGITS-1:0]         dp_in,
   input  logic                          lz_suppress,
   output logic [NUM_DIGITS-1:0]         anode_driver,
   output logic [6:0]                    segments,
   output logic                          dp,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_index
);

   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int CNT_MAX = (PRESCALE > GUARD_CYCLES) ? PRESCALE : GUARD_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] LIT_TC   = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] GUARD_TC = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic             INV      = (ACTIVE_LOW != 0);

   scan_state_t            state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [IDX_W-1:0]       idx, idx_nxt, idx_adv;
   logic [3:0]             nib;
   logic [6:0]             seg_dec;
   logic [NUM_DIGITS-1:0]  lz_mask;
   logic                   zero_run;
   logic                   blank;
   logic [NUM_DIGITS-1:0]  an_hi;
   logic [6:0]             seg_hi;
   logic                   dp_hi;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= LIT;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      idx_adv   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (enable) begin
         case (state)
            LIT: begin
               if (cnt == LIT_TC) begin
                  cnt_nxt = '0;
                  if (GUARD_CYCLES > 0) state_nxt = GUARD;
                  else                  idx_nxt   = idx_adv;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            GUARD: begin
               if (cnt == GUARD_TC) begin
                  cnt_nxt   = '0;
                  idx_nxt   = idx_adv;
                  state_nxt = LIT;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: state_nxt = LIT;
         endcase
      end
   end

   // A digit is a leading zero when it and every digit above it are zero
   always_comb begin
      nib      = '0;
      lz_mask  = '0;
      zero_run = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == k[IDX_W-1:0]) nib = digit_values[4*k +: 4];
      end
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run   = zero_run & (digit_values[4*k +: 4] == 4'h0);
         lz_mask[k] = zero_run;
      end
   end

   hex_to_seven_seg u_dec (
      .nibble (nib),
      .seg    (seg_dec)
   );

   assign blank = digit_blank[idx] | (lz_suppress & lz_mask[idx]);

   always_comb begin
      an_hi  = '0;
      seg_hi = '0;
      dp_hi  = 1'b0;
      if (enable && state == LIT) begin
         an_hi[idx] = 1'b1;
         if (!blank) begin
            seg_hi = seg_dec;
            dp_hi  = dp_in[idx];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         anode_driver <= {NUM_DIGITS{INV}};
         segments     <= {7{INV}};
         dp           <= INV;
         digit_index  <= '0;
      end else begin
         anode_driver <= an_hi ^ {NUM_DIGITS{INV}};
         segments     <= seg_hi ^ {7{INV}};
         dp           <= dp_hi ^ INV;
         digit_index  <= idx;
      end
   end

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench: two scanner configurations checked cycle by cycle against a
// position-based reference model of the scan (digit = slot number of enabled cycles).
module tb_display_scanner;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] digit_values = '0;
   logic [3:0]  digit_blank = '0;
   logic [3:0]  dp_in = '0;
   logic        lz_suppress = 1'b0;

   logic [3:0]  an_a;
   logic [6:0]  seg_a;
   logic        dp_a;
   logic [1:0]  idx_a;
   logic [2:0]  an_b;
   logic [6:0]  seg_b;
   logic        dp_b;
   logic [1:0]  idx_b;

   always #5 clock = ~clock;

   display_scanner #(.NUM_DIGITS(4), .PRESCALE(4), .GUARD_CYCLES(1), .ACTIVE_LOW(1)) dut_a (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .digit_values (digit_values),
      .digit_blank  (digit_blank),
      .dp_in        (dp_in),
      .lz_suppress  (lz_suppress),
      .anode_driver (an_a),
      .segments     (seg_a),
      .dp           (dp_a),
      .digit_index  (idx_a)
   );

   display_scanner #(.NUM_DIGITS(3), .PRESCALE(4), .GUARD_CYCLES(0), .ACTIVE_LOW(0)) dut_b (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .digit_values (digit_values[11:0]),
      .digit_blank  (digit_blank[2:0]),
      .dp_in        (dp_in[2:0]),
      .lz_suppress  (lz_suppress),
      .anode_driver (an_b),
      .segments     (seg_b),
      .dp           (dp_b),
      .digit_index  (idx_b)
   );

   typedef struct {
      logic [7:0] an_a;
      logic [6:0] seg_a;
      logic       dp_a;
      int         idx_a;
      logic [7:0] an_b;
      logic [6:0] seg_b;
      logic       dp_b;
      int         idx_b;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   pos    = 0;

   function automatic logic [6:0] glyph(input int v);
      case (v)
         0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;   3: return 7'h4F;
         4: return 7'h66;   5: return 7'h6D;   6: return 7'h7D;   7: return 7'h07;
         8: return 7'h7F;   9: return 7'h6F;  10: return 7'h77;  11: return 7'h7C;
        12: return 7'h39;  13: return 7'h5E;  14: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // Expected registered outputs after an edge, from the count of enabled cycles
   function automatic void model(input int n, input int p, input int g, input bit al,
                                 input int ps, input logic r, input logic en,
                                 input logic [31:0] vals, input logic [7:0] blk,
                                 input logic [7:0] dpi, input logic lz,
                                 output logic [7:0] an, output logic [6:0] seg,
                                 output logic dpo, output int idx);
      int slot, d, phase;
      logic [31:0] vmask, upper;
      logic [7:0] an_hi;
      logic [6:0] seg_hi;
      logic dp_hi;
      bit dark;
      slot   = p + g;
      d      = (ps / slot) % n;
      phase  = ps % slot;
      an_hi  = '0;
      seg_hi = '0;
      dp_hi  = 1'b0;
      idx    = 0;
      if (!r) begin
         idx = d;
         if (en && phase < p) begin
            vmask  = (32'h1 << (4 * n)) - 32'h1;
            upper  = (vals & vmask) >> (4 * d);
            dark   = blk[d] || (lz && d != 0 && upper == 0);
            an_hi  = 8'h1 << d;
            if (!dark) begin
               seg_hi = glyph(int'((vals >> (4 * d)) & 32'hF));
               dp_hi  = dpi[d];
            end
         end
      end
      an  = al ? ~an_hi : an_hi;
      seg = al ? ~seg_hi : seg_hi;
      dpo = al ? ~dp_hi : dp_hi;
   endfunction

   task automatic step(input logic r, input logic en, input logic [15:0] vals,
                       input logic [3:0] blk, input logic [3:0] dpi, input logic lz);
      exp_t e;
      @(negedge clock);
      reset        = r;
      enable       = en;
      digit_values = vals;
      digit_blank  = blk;
      dp_in        = dpi;
      lz_suppress  = lz;
      model(4, 4, 1, 1'b1, pos, r, en, {16'h0, vals}, {4'h0, blk}, {4'h0, dpi}, lz,
            e.an_a, e.seg_a, e.dp_a, e.idx_a);
      model(3, 4, 0, 1'b0, pos, r, en, {16'h0, vals}, {4'h0, blk}, {4'h0, dpi}, lz,
            e.an_b, e.seg_b, e.dp_b, e.idx_b);
      sb.push_back(e);
      if (r)       pos = 0;
      else if (en) pos = pos + 1;
   endtask

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endfunction

   always @(posedge clock) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("a_anode", {28'h0, an_a}, {28'h0, e.an_a[3:0]});
         chk("a_segments", {25'h0, seg_a}, {25'h0, e.seg_a});
         chk("a_dp", {31'h0, dp_a}, {31'h0, e.dp_a});
         chk("a_index", {30'h0, idx_a}, e.idx_a);
         chk("b_anode", {29'h0, an_b}, {29'h0, e.an_b[2:0]});
         chk("b_segments", {25'h0, seg_b}, {25'h0, e.seg_b});
         chk("b_dp", {31'h0, dp_b}, {31'h0, e.dp_b});
         chk("b_index", {30'h0, idx_b}, e.idx_b);
      end
   end

   initial begin
      logic [15:0] v;
      logic [3:0]  bl, dpr;
      logic        lz, en, r;

      repeat (3) step(1'b1, 1'b1, 16'h12AF, 4'h0, 4'h0, 1'b0);
      repeat (45) step(1'b0, 1'b1, 16'h12AF, 4'h0, 4'h0, 1'b0);

      step(1'b1, 1'b1, 16'h0050, 4'h0, 4'b1000, 1'b1);
      repeat (25) step(1'b0, 1'b1, 16'h0050, 4'h0, 4'b1000, 1'b1);

      // enable drops on digit 1's last lit cycle, then resumes
      step(1'b1, 1'b1, 16'h3C9E, 4'h0, 4'b0110, 1'b0);
      while (pos % 20 != 8) step(1'b0, 1'b1, 16'h3C9E, 4'h0, 4'b0110, 1'b0);
      repeat (3) step(1'b0, 1'b0, 16'h3C9E, 4'h0, 4'b0110, 1'b0);
      repeat (12) step(1'b0, 1'b1, 16'h3C9E, 4'h0, 4'b0110, 1'b0);

      // reset while the guard interval is showing
      while (pos % 5 != 4) step(1'b0, 1'b1, 16'h7D84, 4'b0100, 4'h1, 1'b0);
      step(1'b1, 1'b1, 16'h7D84, 4'b0100, 4'h1, 1'b0);
      repeat (10) step(1'b0, 1'b1, 16'h7D84, 4'b0100, 4'h1, 1'b0);

      v = 16'h0000; bl = 4'h0; dpr = 4'h0; lz = 1'b1;
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            for (int k = 0; k < 4; k++)
               v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 15) == 0) bl  = 4'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 15) == 0) dpr = 4'($urandom);
         if ($urandom_range(0, 31) == 0) lz  = 1'($urandom);
         en = ($urandom_range(0, 9) != 0);
         r  = ($urandom_range(0, 99) == 0);
         step(r, en, v, bl, dpr, lz);
      end

      repeat (3) @(negedge clock);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
